// File: rtl/axi_slave_mem_if.sv
// AXI4 bus bundle between a master and the axi_slave_mem responder.
// Carries the five AXI4 channels: AW, W and B for writes, and AR and R for reads.
//   master modport : drives AW/W/AR payload and valids, bready, rready
//   slave modport  : drives awready, wready, arready and the B/R channels
interface axi_slave_mem_if #(
    parameter int AW = 32,
    parameter int DW = 64
);
    logic [AW-1:0]   awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic            awvalid;
    logic            awready;

    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;

    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    logic [AW-1:0]   araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic            arvalid;
    logic            arready;

    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    modport master (
        output awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_slave_mem.sv
// AXI4 memory responder. Write bursts arrive on AW/W and are answered on B.
// Read bursts arrive on AR and are answered on R. Storage is a word-addressed
// array of DEPTH words, DW bits each.
// Ports:
//   clk : clock
//   rst : synchronous active-high reset
//   axi : axi_slave_mem_if.slave carrying all five AXI channels
//
// Write FSM
//   state  | meaning
//   W_IDLE | awready high, waiting for an address
//   W_DATA | wready high, taking beats until count == len
//   W_RESP | bvalid high, holding bresp until bready
// Read FSM
//   state  | meaning
//   R_IDLE | arready high, waiting for an address
//   R_DATA | rvalid high, presenting registered beats until rlast is accepted
module axi_slave_mem #(
    parameter int AW    = 32,
    parameter int DW    = 64,
    parameter int DEPTH = 256
) (
    input  logic            clk,
    input  logic            rst,
    axi_slave_mem_if.slave  axi
);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [DW-1:0] mem [DEPTH];

    // ---------------- write channel ----------------
    w_state_t      w_state, w_state_nxt;
    logic [IW-1:0] w_idx;
    logic [7:0]    w_len;
    logic [7:0]    w_cnt;
    logic          w_incr;
    logic          w_err;
    logic          aw_hs, w_hs, w_last_beat, aw_bad;

    assign aw_hs       = axi.awvalid && axi.awready;
    assign w_hs        = axi.wvalid && axi.wready;
    assign w_last_beat = (w_cnt == w_len);
    assign aw_bad      = (axi.awsize != 3'd3) || axi.awburst[1];

    always_ff @(posedge clk) begin
        if (rst) w_state <= W_IDLE;
        else     w_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = w_state;
        case (w_state)
            W_IDLE:  if (axi.awvalid)                w_state_nxt = W_DATA;
            W_DATA:  if (axi.wvalid && w_last_beat)  w_state_nxt = W_RESP;
            W_RESP:  if (axi.bready)                 w_state_nxt = W_IDLE;
            default:                                 w_state_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        axi.awready = (w_state == W_IDLE);
        axi.wready  = (w_state == W_DATA);
        axi.bvalid  = (w_state == W_RESP);
        axi.bresp   = ((w_state == W_RESP) && w_err) ? 2'b10 : 2'b00;
    end

    // Only the word index is kept: +8 on the byte address is +1 on the index,
    // and the index wraps modulo DEPTH on its own.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_idx  <= '0;
            w_len  <= '0;
            w_cnt  <= '0;
            w_incr <= 1'b0;
            w_err  <= 1'b0;
        end else if (aw_hs) begin
            w_idx  <= axi.awaddr[IW+2:3];
            w_len  <= axi.awlen;
            w_cnt  <= '0;
            w_incr <= (axi.awburst == 2'b01);
            w_err  <= aw_bad;
        end else if (w_hs) begin
            // The burst length is authoritative; a misplaced wlast only flags an error.
            if (axi.wlast != w_last_beat) w_err <= 1'b1;
            if (!w_last_beat)             w_cnt <= w_cnt + 8'd1;
            if (w_incr)                   w_idx <= w_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_hs && !w_err) begin
            for (int b = 0; b < DW/8; b++) begin
                if (axi.wstrb[b]) mem[w_idx][8*b +: 8] <= axi.wdata[8*b +: 8];
            end
        end
    end

    // ---------------- read channel ----------------
    r_state_t      r_state, r_state_nxt;
    logic [IW-1:0] r_idx, r_idx_nxt;
    logic [7:0]    r_len;
    logic [7:0]    r_cnt, r_cnt_nxt;
    logic          r_incr;
    logic          r_err;
    logic          r_last;
    logic [DW-1:0] r_data;
    logic          ar_hs, r_hs, ar_bad;

    assign ar_hs     = axi.arvalid && axi.arready;
    assign r_hs      = axi.rvalid && axi.rready;
    assign ar_bad    = (axi.arsize != 3'd3) || axi.arburst[1];
    assign r_idx_nxt = r_incr ? r_idx + 1'b1 : r_idx;
    assign r_cnt_nxt = r_cnt + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) r_state <= R_IDLE;
        else     r_state <= r_state_nxt;
    end

    always_comb begin
        r_state_nxt = r_state;
        case (r_state)
            R_IDLE:  if (axi.arvalid)           r_state_nxt = R_DATA;
            R_DATA:  if (axi.rready && r_last)  r_state_nxt = R_IDLE;
            default:                            r_state_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        axi.arready = (r_state == R_IDLE);
        axi.rvalid  = (r_state == R_DATA);
        axi.rresp   = ((r_state == R_DATA) && r_err) ? 2'b10 : 2'b00;
        axi.rlast   = r_last;
        axi.rdata   = r_data;
    end

    // rdata is loaded from the array on the same edge a write may land, so a
    // colliding write is seen only on a later beat (read-before-write).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx  <= '0;
            r_len  <= '0;
            r_cnt  <= '0;
            r_incr <= 1'b0;
            r_err  <= 1'b0;
            r_last <= 1'b0;
            r_data <= '0;
        end else if (ar_hs) begin
            r_idx  <= axi.araddr[IW+2:3];
            r_len  <= axi.arlen;
            r_cnt  <= '0;
            r_incr <= (axi.arburst == 2'b01);
            r_err  <= ar_bad;
            r_last <= (axi.arlen == 8'd0);
            r_data <= ar_bad ? '0 : mem[axi.araddr[IW+2:3]];
        end else if (r_hs) begin
            if (r_last) begin
                r_last <= 1'b0;
            end else begin
                r_idx  <= r_idx_nxt;
                r_cnt  <= r_cnt_nxt;
                r_last <= (r_cnt_nxt == r_len);
                r_data <= r_err ? '0 : mem[r_idx_nxt];
            end
        end
    end
endmodule

// File: tb/tb_axi_slave_mem.sv
module tb_axi_slave_mem;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_slave_mem_if #(.AW(32), .DW(64)) axi ();

    axi_slave_mem #(.AW(32), .DW(64), .DEPTH(256)) dut (
        .clk (clk),
        .rst (rst),
        .axi (axi)
    );

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } rexp_t;

    rexp_t       r_q[$];
    logic [1:0]  b_q[$];
    logic [63:0] tb_mem [256];
    logic [63:0] wbuf [16];
    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [7:0] idx(input logic [31:0] a);
        return a[10:3];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic write_burst(input logic [31:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst,
                               input logic [7:0] strb, input int wlast_beat,
                               input int bready_delay);
        logic        err;
        logic [31:0] a;
        logic [1:0]  exp_b;
        int          t;
        err = (size != 3'd3) || (burst > 2'd1) || (wlast_beat != int'(len));
        b_q.push_back(err ? 2'b10 : 2'b00);
        if (!err) begin
            a = addr;
            for (int i = 0; i <= int'(len); i++) begin
                for (int b = 0; b < 8; b++)
                    if (strb[b]) tb_mem[idx(a)][8*b +: 8] = wbuf[i][8*b +: 8];
                if (burst == 2'b01) a = a + 32'd8;
            end
        end
        @(negedge clk);
        axi.awaddr = addr; axi.awlen = len; axi.awsize = size; axi.awburst = burst;
        axi.awvalid = 1'b1;
        t = 0;
        while (!axi.awready && t < 50) begin @(negedge clk); t++; end
        check("awready", axi.awready, 1);
        @(negedge clk);
        axi.awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            axi.wdata = wbuf[i]; axi.wstrb = strb; axi.wlast = (i == wlast_beat);
            axi.wvalid = 1'b1;
            t = 0;
            while (!axi.wready && t < 20) begin @(negedge clk); t++; end
            if (i == 0 || i == int'(len)) check("wready", axi.wready, 1);
            @(negedge clk);
        end
        axi.wvalid = 1'b0; axi.wlast = 1'b0;
        check("b_latency", axi.bvalid, 1);
        exp_b = b_q.pop_front();
        check("bresp", axi.bresp, exp_b);
        for (int d = 0; d < bready_delay; d++) begin
            @(negedge clk);
            check("b_hold_valid", axi.bvalid, 1);
            check("b_hold_resp", axi.bresp, exp_b);
            check("b_hold_awready", axi.awready, 0);
        end
        axi.bready = 1'b1;
        @(negedge clk);
        axi.bready = 1'b0;
        check("b_done_valid", axi.bvalid, 0);
        check("b_done_awready", axi.awready, 1);
    endtask

    task automatic read_burst(input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst,
                              input int rready_delay);
        logic        err;
        logic [31:0] a;
        rexp_t       e;
        int          t;
        err = (size != 3'd3) || (burst > 2'd1);
        a = addr;
        for (int i = 0; i <= int'(len); i++) begin
            e.data = err ? 64'd0 : tb_mem[idx(a)];
            e.resp = err ? 2'b10 : 2'b00;
            e.last = (i == int'(len));
            r_q.push_back(e);
            if (burst == 2'b01) a = a + 32'd8;
        end
        @(negedge clk);
        axi.araddr = addr; axi.arlen = len; axi.arsize = size; axi.arburst = burst;
        axi.arvalid = 1'b1;
        t = 0;
        while (!axi.arready && t < 50) begin @(negedge clk); t++; end
        check("arready", axi.arready, 1);
        @(negedge clk);
        axi.arvalid = 1'b0;
        check("r_latency", axi.rvalid, 1);
        for (int i = 0; i <= int'(len); i++) begin
            t = 0;
            while (!axi.rvalid && t < 20) begin @(negedge clk); t++; end
            e = r_q.pop_front();
            check("rdata", axi.rdata, e.data);
            check("rresp", axi.rresp, e.resp);
            check("rlast", axi.rlast, e.last);
            if (i == 0) begin
                for (int d = 0; d < rready_delay; d++) begin
                    @(negedge clk);
                    check("r_hold_valid", axi.rvalid, 1);
                    check("r_hold_data", axi.rdata, e.data);
                    check("r_hold_last", axi.rlast, e.last);
                end
            end
            axi.rready = 1'b1;
            @(negedge clk);
            axi.rready = 1'b0;
        end
        check("r_done_valid", axi.rvalid, 0);
        check("r_done_arready", axi.arready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0; axi.awvalid = 1'b0;
        axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0; axi.bready = 1'b0;
        axi.araddr = '0; axi.arlen = '0; axi.arsize = '0; axi.arburst = '0; axi.arvalid = 1'b0;
        axi.rready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // reset state
        check("rst_awready", axi.awready, 1);
        check("rst_arready", axi.arready, 1);
        check("rst_wready", axi.wready, 0);
        check("rst_bvalid", axi.bvalid, 0);
        check("rst_rvalid", axi.rvalid, 0);
        check("rst_rlast", axi.rlast, 0);
        check("rst_bresp", axi.bresp, 0);
        check("rst_rresp", axi.rresp, 0);
        check("rst_rdata", axi.rdata, 0);

        // INCR 4-beat write and read back
        wbuf[0] = 64'h1111_1111_1111_1111; wbuf[1] = 64'h2222_2222_2222_2222;
        wbuf[2] = 64'h3333_3333_3333_3333; wbuf[3] = 64'h4444_4444_4444_4444;
        write_burst(32'h100, 8'd3, 3'd3, 2'b01, 8'hFF, 3, 0);
        read_burst(32'h100, 8'd3, 3'd3, 2'b01, 0);

        // partial strobe
        wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        write_burst(32'h20, 8'd0, 3'd3, 2'b01, 8'hFF, 0, 0);
        wbuf[0] = 64'h0;
        write_burst(32'h20, 8'd0, 3'd3, 2'b01, 8'h0F, 0, 0);
        check("strobe_model", tb_mem[4], 64'hFFFF_FFFF_0000_0000);
        read_burst(32'h20, 8'd0, 3'd3, 2'b01, 0);

        // backpressure
        read_burst(32'h100, 8'd1, 3'd3, 2'b01, 3);
        wbuf[0] = 64'h0123_4567_89AB_CDEF;
        write_burst(32'h200, 8'd0, 3'd3, 2'b01, 8'hFF, 0, 2);
        read_burst(32'h200, 8'd0, 3'd3, 2'b01, 0);

        // error cases
        wbuf[0] = 64'hDEAD_BEEF_DEAD_BEEF;
        write_burst(32'h100, 8'd0, 3'd2, 2'b01, 8'hFF, 0, 0);
        read_burst(32'h100, 8'd0, 3'd3, 2'b01, 0);
        wbuf[0] = 64'hA; wbuf[1] = 64'hB; wbuf[2] = 64'hC;
        write_burst(32'h300, 8'd2, 3'd3, 2'b01, 8'hFF, 1, 1);
        read_burst(32'h100, 8'd2, 3'd3, 2'b10, 0);

        // address wrap and FIXED burst
        wbuf[0] = 64'h5555_0000_0000_00F8; wbuf[1] = 64'h6666_0000_0000_0000;
        write_burst(32'h7F8, 8'd1, 3'd3, 2'b01, 8'hFF, 1, 0);
        read_burst(32'h0, 8'd0, 3'd3, 2'b01, 0);
        read_burst(32'h7F8, 8'd0, 3'd3, 2'b01, 0);
        wbuf[0] = 64'h7777_0001; wbuf[1] = 64'h7777_0002; wbuf[2] = 64'h7777_0003;
        write_burst(32'h40, 8'd2, 3'd3, 2'b00, 8'hFF, 2, 0);
        check("fixed_model", tb_mem[8], 64'h7777_0003);
        read_burst(32'h40, 8'd0, 3'd3, 2'b01, 0);

        // concurrent read and write
        wbuf[0] = 64'h9000_0000_0000_0001; wbuf[1] = 64'h9000_0000_0000_0002;
        wbuf[2] = 64'h9000_0000_0000_0003; wbuf[3] = 64'h9000_0000_0000_0004;
        fork
            write_burst(32'h400, 8'd3, 3'd3, 2'b01, 8'hFF, 3, 0);
            read_burst(32'h100, 8'd3, 3'd3, 2'b01, 0);
        join
        read_burst(32'h400, 8'd3, 3'd3, 2'b01, 0);

        // reset during write beat 2
        @(negedge clk);
        axi.awaddr = 32'h500; axi.awlen = 8'd3; axi.awsize = 3'd3; axi.awburst = 2'b01;
        axi.awvalid = 1'b1;
        check("mid_awready", axi.awready, 1);
        @(negedge clk);
        axi.awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            axi.wdata = 64'hBAD0 + 64'(i); axi.wstrb = 8'hFF; axi.wlast = 1'b0; axi.wvalid = 1'b1;
            check("mid_wready", axi.wready, 1);
            @(negedge clk);
        end
        axi.wdata = 64'hBAD2; axi.wvalid = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; axi.wvalid = 1'b0; axi.bready = 1'b1;
        check("mid_rst_awready", axi.awready, 1);
        check("mid_rst_wready", axi.wready, 0);
        check("mid_rst_bvalid", axi.bvalid, 0);
        for (int d = 0; d < 4; d++) begin
            @(negedge clk);
            check("mid_rst_no_b", axi.bvalid, 0);
        end
        axi.bready = 1'b0;

        check("b_queue_empty", 64'(b_q.size()), 0);
        check("r_queue_empty", 64'(r_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
